// File: rtl/axis_wrr_mux2_pkg.sv
// ============================================================================
// axis_wrr_mux2_pkg : shared state encodings and source ids for axis_wrr_mux2
// Rev 1.0
// ============================================================================
`default_nettype none

package axis_wrr_mux2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/axis_reg_slice.sv
// ============================================================================
// axis_reg_slice : single-stage registered AXIS output slice
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_reg_slice #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_load,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  assign o_load = !o_valid || i_ready;

  // Payload only updates on a real beat so it stays frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (o_load) begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data <= i_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_wrr_mux2.sv
// ============================================================================
// axis_wrr_mux2 : packet-aware 2:1 weighted round-robin AXIS merge
// Optional AXIS_WRR_MUX2_CNT_EN adds per-source packet counters.  Rev 1.0
// ============================================================================
`default_nettype none

module axis_wrr_mux2 #(
  parameter int DWIDTH = 16,
  parameter int WWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_a_tvalid,
  output logic              s_a_tready,
  input  logic [DWIDTH-1:0] s_a_tdata,
  input  logic              s_a_tlast,
  input  logic              s_b_tvalid,
  output logic              s_b_tready,
  input  logic [DWIDTH-1:0] s_b_tdata,
  input  logic              s_b_tlast,
  input  logic [WWIDTH-1:0] weight_a,
  input  logic [WWIDTH-1:0] weight_b,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tid,
`ifdef AXIS_WRR_MUX2_CNT_EN
  output logic              busy,
  output logic [31:0]       pkt_cnt_a,
  output logic [31:0]       pkt_cnt_b
`else
  output logic              busy
`endif
);

  import axis_wrr_mux2_pkg::*;

  localparam int SLICE_W = DWIDTH + 2;

  state_t            r_state;
  logic [WWIDTH-1:0] r_credit;
  logic              r_last_src;
  logic              r_pkt_open;

  logic              w_load;
  logic              w_serve_b;
  logic              w_acc;
  logic              w_last;
  logic              w_own_valid;
  logic              w_oth_valid;
  logic [WWIDTH-1:0] w_wa;
  logic [WWIDTH-1:0] w_wb;
  logic [WWIDTH-1:0] w_own_w;
  logic [WWIDTH-1:0] w_oth_w;
  logic [WWIDTH-1:0] w_credit_dec;
  logic [SLICE_W-1:0] w_slice_in;
  logic [SLICE_W-1:0] w_slice_out;

  assign w_wa         = (weight_a == '0) ? WWIDTH'(1) : weight_a;
  assign w_wb         = (weight_b == '0) ? WWIDTH'(1) : weight_b;
  assign w_serve_b    = (r_state == SERVE_B);
  assign s_a_tready   = (r_state == SERVE_A) && w_load;
  assign s_b_tready   = w_serve_b && w_load;
  assign w_acc        = (s_a_tvalid && s_a_tready) || (s_b_tvalid && s_b_tready);
  assign w_last       = w_serve_b ? s_b_tlast  : s_a_tlast;
  assign w_own_valid  = w_serve_b ? s_b_tvalid : s_a_tvalid;
  assign w_oth_valid  = w_serve_b ? s_a_tvalid : s_b_tvalid;
  assign w_own_w      = w_serve_b ? w_wb : w_wa;
  assign w_oth_w      = w_serve_b ? w_wa : w_wb;
  assign w_credit_dec = r_credit - WWIDTH'(1);
  assign w_slice_in   = {w_serve_b, w_last, (w_serve_b ? s_b_tdata : s_a_tdata)};
  assign busy         = (r_state != IDLE);

  axis_reg_slice #(
    .WIDTH (SLICE_W)
  ) u_out_slice (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_acc),
    .i_data  (w_slice_in),
    .o_load  (w_load),
    .o_valid (m_tvalid),
    .o_data  (w_slice_out),
    .i_ready (m_tready)
  );

  assign {m_tid, m_tlast, m_tdata} = w_slice_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_credit   <= '0;
      r_last_src <= SRC_B;
      r_pkt_open <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_a_tvalid && (!s_b_tvalid || (r_last_src == SRC_B))) begin
            r_state    <= SERVE_A;
            r_credit   <= w_wa;
            r_last_src <= SRC_A;
          end else if (s_b_tvalid) begin
            r_state    <= SERVE_B;
            r_credit   <= w_wb;
            r_last_src <= SRC_B;
          end
        end
        SERVE_A, SERVE_B: begin
          if (w_acc && w_last) begin
            // End of packet: re-arbitrate in the same cycle so no bubble is inserted.
            r_pkt_open <= 1'b0;
            if ((w_credit_dec != '0) && w_own_valid) begin
              r_credit <= w_credit_dec;
            end else if (w_oth_valid) begin
              r_state    <= w_serve_b ? SERVE_A : SERVE_B;
              r_credit   <= w_oth_w;
              r_last_src <= w_serve_b ? SRC_A : SRC_B;
            end else if (w_own_valid) begin
              r_credit <= w_own_w;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_acc) begin
            r_pkt_open <= 1'b1;
          end else if (!r_pkt_open && !w_own_valid) begin
            // Between packets with nothing offered by the owner: release the grant.
            if (w_oth_valid) begin
              r_state    <= w_serve_b ? SERVE_A : SERVE_B;
              r_credit   <= w_oth_w;
              r_last_src <= w_serve_b ? SRC_A : SRC_B;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_WRR_MUX2_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_a <= '0;
      pkt_cnt_b <= '0;
    end else if (m_tvalid && m_tready && m_tlast) begin
      if (m_tid == SRC_B) begin
        pkt_cnt_b <= pkt_cnt_b + 32'd1;
      end else begin
        pkt_cnt_a <= pkt_cnt_a + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_wrr_mux2.sv
// ============================================================================
// tb_axis_wrr_mux2 : directed self-checking bench for axis_wrr_mux2
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axis_wrr_mux2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_a_tvalid, s_a_tready, s_a_tlast;
  logic [15:0] s_a_tdata;
  logic        s_b_tvalid, s_b_tready, s_b_tlast;
  logic [15:0] s_b_tdata;
  logic [3:0]  weight_a, weight_b;
  logic        m_tvalid, m_tready, m_tlast, m_tid;
  logic [15:0] m_tdata;
  logic        busy;
`ifdef AXIS_WRR_MUX2_CNT_EN
  logic [31:0] pkt_cnt_a, pkt_cnt_b;
`endif

  axis_wrr_mux2 #(.DWIDTH(16), .WWIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_a_tvalid (s_a_tvalid),
    .s_a_tready (s_a_tready),
    .s_a_tdata  (s_a_tdata),
    .s_a_tlast  (s_a_tlast),
    .s_b_tvalid (s_b_tvalid),
    .s_b_tready (s_b_tready),
    .s_b_tdata  (s_b_tdata),
    .s_b_tlast  (s_b_tlast),
    .weight_a   (weight_a),
    .weight_b   (weight_b),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tid      (m_tid),
`ifdef AXIS_WRR_MUX2_CNT_EN
    .busy       (busy),
    .pkt_cnt_a  (pkt_cnt_a),
    .pkt_cnt_b  (pkt_cnt_b)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bt(input logic id, input logic last, input logic [15:0] d);
    return {14'b0, id, last, d};
  endfunction

  // Source models: each behaves like an AXIS FIFO output fed from a queue.
  logic [16:0] qa[$];
  logic [16:0] qb[$];
  logic        a_hs_q, b_hs_q;
  int          a_sent = 0;
  int          a_gap_at = -1;
  int          a_gap_len = 0;
  int          a_gapcnt = 0;
  wire         a_hs_w = s_a_tvalid && s_a_tready;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    a_hs_q <= s_a_tvalid && s_a_tready;
    b_hs_q <= s_b_tvalid && s_b_tready;
  end

  initial begin
    s_a_tvalid = 1'b0; s_a_tdata = '0; s_a_tlast = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (a_hs_q) begin
        void'(qa.pop_front());
        a_sent++;
        if (a_sent == a_gap_at) a_gapcnt = a_gap_len;
      end
      if (a_gapcnt != 0) begin
        s_a_tvalid = 1'b0;
        a_gapcnt--;
      end else if (qa.size() != 0) begin
        s_a_tvalid = 1'b1;
        {s_a_tlast, s_a_tdata} = qa[0];
      end else begin
        s_a_tvalid = 1'b0;
      end
    end
  end

  initial begin
    s_b_tvalid = 1'b0; s_b_tdata = '0; s_b_tlast = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (b_hs_q) void'(qb.pop_front());
      if (qb.size() != 0) begin
        s_b_tvalid = 1'b1;
        {s_b_tlast, s_b_tdata} = qb[0];
      end else begin
        s_b_tvalid = 1'b0;
      end
    end
  end

  // Output monitor: ordered scoreboard plus hold-while-stalled check.
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_beat = '0;
  int          out_cnt = 0;
  int          out_cyc[0:255];

  always @(negedge clk) begin
    if (mon_en && prev_stall && m_tvalid)
      check("hold", bt(m_tid, m_tlast, m_tdata), prev_beat);
    if (mon_en && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) check("extra_beat", 32'(exp_q.size()), 32'd1);
      else check("beat", bt(m_tid, m_tlast, m_tdata), exp_q.pop_front());
      out_cyc[out_cnt % 256] = cyc;
      out_cnt++;
    end
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = bt(m_tid, m_tlast, m_tdata);
  end

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int s;
    rst = 1'b1; m_tready = 1'b1; weight_a = 4'd1; weight_b = 4'd1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 16'h0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tid", m_tid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_treadys", {s_a_tready, s_b_tready}, 2'b00);

    // Basic merge: one 3-beat A packet.
    qa.push_back({1'b0, 16'hA001}); qa.push_back({1'b0, 16'hA002}); qa.push_back({1'b1, 16'hA003});
    exp_q.push_back(bt(0, 0, 16'hA001)); exp_q.push_back(bt(0, 0, 16'hA002));
    exp_q.push_back(bt(0, 1, 16'hA003));
    n = 0;
    do begin @(negedge clk); n++; end while (!a_hs_w && n < 20);
    @(negedge clk);
    check("lat_valid", m_tvalid, 1'b1);
    check("lat_data", m_tdata, 16'hA001);
    drain("basic_drain");
    repeat (3) @(negedge clk);
    check("basic_busy_low", busy, 1'b0);

    // Fair tie: 2-beat packets on both, weights 1/1.
    do_reset();
    s = out_cnt;
    for (int p = 0; p < 4; p++) begin
      for (int b = 0; b < 2; b++) begin
        qa.push_back({b == 1, 16'(16'hA100 + p * 2 + b)});
        qb.push_back({b == 1, 16'(16'hB100 + p * 2 + b)});
      end
      for (int b = 0; b < 2; b++) exp_q.push_back(bt(0, b == 1, 16'(16'hA100 + p * 2 + b)));
      for (int b = 0; b < 2; b++) exp_q.push_back(bt(1, b == 1, 16'(16'hB100 + p * 2 + b)));
    end
    drain("fair_drain");
    check("fair_gapless", 32'(out_cyc[(s + 15) % 256] - out_cyc[s % 256]), 32'd15);
    repeat (3) @(negedge clk);

    // Weighting 3/1 with single-beat packets: A,A,A,B,A,A,A,B.
    do_reset();
    weight_a = 4'd3; weight_b = 4'd1;
    for (int i = 0; i < 6; i++) qa.push_back({1'b1, 16'(16'h3A00 + i)});
    for (int i = 0; i < 2; i++) qb.push_back({1'b1, 16'(16'h3B00 + i)});
    for (int i = 0; i < 3; i++) exp_q.push_back(bt(0, 1, 16'(16'h3A00 + i)));
    exp_q.push_back(bt(1, 1, 16'h3B00));
    for (int i = 3; i < 6; i++) exp_q.push_back(bt(0, 1, 16'(16'h3A00 + i)));
    exp_q.push_back(bt(1, 1, 16'h3B01));
    drain("w31_drain");
    repeat (3) @(negedge clk);

    // weight_a = 0 behaves as 1: strict alternation.
    do_reset();
    weight_a = 4'd0; weight_b = 4'd1;
    for (int i = 0; i < 3; i++) begin
      qa.push_back({1'b1, 16'(16'h0A00 + i)});
      qb.push_back({1'b1, 16'(16'h0B00 + i)});
      exp_q.push_back(bt(0, 1, 16'(16'h0A00 + i)));
      exp_q.push_back(bt(1, 1, 16'(16'h0B00 + i)));
    end
    drain("w01_drain");
    repeat (3) @(negedge clk);

    // Backpressure 1010 with a 2-cycle A gap mid-packet while B waits.
    do_reset();
    weight_a = 4'd1; weight_b = 4'd1;
    a_gap_at = a_sent + 2; a_gap_len = 2;
    for (int i = 0; i < 4; i++) begin
      qa.push_back({i == 3, 16'(16'hC000 + i)});
      exp_q.push_back(bt(0, i == 3, 16'(16'hC000 + i)));
    end
    qb.push_back({1'b1, 16'hD000});
    exp_q.push_back(bt(1, 1, 16'hD000));
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1 m_tready = ~m_tready;
      n++;
    end
    check("bp_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 m_tready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during beat 2 of 4: output cleared, arbitration restarts with A.
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) qa.push_back({i == 3, 16'(16'hE000 + i)});
    qb.push_back({1'b1, 16'hF000});
    n = 0;
    do begin @(negedge clk); n++; end while (!(a_hs_w && s_a_tdata == 16'hE001) && n < 50);
    check("rst_wait_timeout", 32'(n >= 50), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(bt(0, 0, 16'hE002));
    exp_q.push_back(bt(0, 1, 16'hE003));
    exp_q.push_back(bt(1, 1, 16'hF000));
    mon_en = 1'b1;
    @(negedge clk);
    check("midrst_m_tvalid", m_tvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_treadys", {s_a_tready, s_b_tready}, 2'b00);
    drain("midrst_drain");
    repeat (3) @(negedge clk);

`ifdef AXIS_WRR_MUX2_CNT_EN
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) qa.push_back({1'b1, 16'(16'h5A00 + i)});
    for (int i = 0; i < 7; i++) qb.push_back({1'b1, 16'(16'h7B00 + i)});
    repeat (60) @(negedge clk);
    check("pkt_cnt_a", pkt_cnt_a, 32'd5);
    check("pkt_cnt_b", pkt_cnt_b, 32'd7);
    mon_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
